// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop process the operands
// LSB first, one bit per clock. The result is assembled in a right-shifting
// register and copied to sum/cout on the final bit, where it stays until the
// next completion.
`timescale 1ns/1ps

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_reg_q, a_reg_d;
   logic [WIDTH-1:0] b_reg_q, b_reg_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic             bit_s;
   logic             bit_c;
   logic [WIDTH-1:0] res_shift;

   // Full-adder slice on the current LSBs and the running carry.
   always_comb begin
      bit_s = a_reg_q[0] ^ b_reg_q[0] ^ carry_q;
      bit_c = (a_reg_q[0] & b_reg_q[0]) | (a_reg_q[0] & carry_q) | (b_reg_q[0] & carry_q);
   end

   // Result register shifted right with the new sum bit entering at the MSB.
   always_comb begin
      res_shift            = res_q >> 1;
      res_shift[WIDTH-1]   = bit_s;
   end

   // Next-state and next-output logic; busy/done follow the state being entered.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d = state_q;
      a_reg_d = a_reg_q;
      b_reg_d = b_reg_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_reg_d = a;
               b_reg_d = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // start is deliberately not looked at here: a running add cannot be restarted.
            a_reg_d = a_reg_q >> 1;
            b_reg_d = b_reg_q >> 1;
            carry_d = bit_c;
            res_d   = res_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               sum_d   = res_shift;
               cout_d  = bit_c;
               done_d  = 1'b1;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears everything so an aborted run leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_reg_q <= '0;
         b_reg_q <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q <= state_d;
         a_reg_q <= a_reg_d;
         b_reg_q <= b_reg_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1. Expected values
// come from plain integer addition of the accepted operands.
`timescale 1ns/1ps

module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic       st8, ci8, busy8, done8, co8;
   logic [7:0] a8, b8, sum8;

   logic       st1, ci1, busy1, done1, co1;
   logic [0:0] a1, b1, sum1;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(ci8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(co8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(ci1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(co1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 addition: accept, scramble inputs, wait (bounded) for done.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
      logic [8:0] exp;
      int lat;
      exp = 9'(a) + 9'(b) + 9'(c);
      a8 = a; b8 = b; ci8 = c; st8 = 1'b1;
      step();
      st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      check({tag, " busy"}, 64'(busy8), 64'd1);
      lat = 0;
      while (!done8 && lat < 20) begin
         step();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'd8);
      check({tag, " result"}, 64'({co8, sum8}), 64'(exp));
      step();
      check({tag, " done width"}, 64'(done8), 64'd0);
   endtask

   // One WIDTH=1 addition.
   task automatic run1(input logic a, input logic b, input logic c, input string tag);
      logic [1:0] exp;
      int lat;
      exp = 2'(a) + 2'(b) + 2'(c);
      a1 = a; b1 = b; ci1 = c; st1 = 1'b1;
      step();
      st1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      check({tag, " busy"}, 64'(busy1), 64'd1);
      lat = 0;
      while (!done1 && lat < 10) begin
         step();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'd1);
      check({tag, " result"}, 64'({co1, sum1}), 64'(exp));
      step();
      check({tag, " done width"}, 64'(done1), 64'd0);
   endtask

   initial begin
      int pulses;
      int lat;

      rst_n = 1'b0;
      st8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
      st1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;

      // Reset state.
      step(); step();
      check("reset w8 outputs", 64'({busy8, done8, co8, sum8}), 64'd0);
      check("reset w1 outputs", 64'({busy1, done1, co1, sum1}), 64'd0);
      #2 rst_n = 1'b1;
      step();

      // 0x0F + 0x01: exact busy/done timeline across edges 0..9.
      a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; st8 = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         step();
         if (k == 0) st8 = 1'b0;
         check("r28 busy", 64'(busy8), 64'(k < 8));
         check("r28 done", 64'(done8), 64'(k == 8));
      end
      check("r28 result held", 64'({co8, sum8}), 64'h010);

      // Carry boundaries.
      run8(8'hFF, 8'h01, 1'b0, "ff+01");
      run8(8'hFF, 8'hFF, 1'b1, "ff+ff+1");
      run8(8'h00, 8'h00, 1'b0, "zero");

      // start held high during RUN with operands toggling.
      a8 = 8'hC3; b8 = 8'h5A; ci8 = 1'b1; st8 = 1'b1;
      step();
      pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
         step();
         if (done8) pulses++;
      end
      st8 = 1'b0;
      check("hold-start done", 64'(done8), 64'd1);
      check("hold-start result", 64'({co8, sum8}), 64'h11E);
      step();
      if (done8) pulses++;
      check("hold-start pulses", 64'(pulses), 64'd1);

      // Reset in the middle of a run.
      a8 = 8'h3C; b8 = 8'h55; ci8 = 1'b0; st8 = 1'b1;
      step();
      st8 = 1'b0;
      step(); step(); step();
      #2 rst_n = 1'b0;
      #1;
      check("midrun reset outputs", 64'({busy8, done8, co8, sum8}), 64'd0);
      step(); step();
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done8 || busy8) pulses++;
      end
      check("no done after reset", 64'(pulses), 64'd0);
      run8(8'h3C, 8'h55, 1'b0, "after reset");

      // Back-to-back: start held through DONE with new operands.
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; st8 = 1'b1;
      step();
      lat = 0;
      while (!done8 && lat < 20) begin
         step();
         lat++;
      end
      check("b2b first latency", 64'(lat), 64'd8);
      check("b2b first result", 64'({co8, sum8}), 64'h046);
      a8 = 8'hA0; b8 = 8'h70; ci8 = 1'b1;
      step();
      st8 = 1'b0;
      check("b2b restart busy", 64'({busy8, done8}), 64'b10);
      for (int k = 1; k <= 7; k++) begin
         step();
         check("b2b first held", 64'({done8, co8, sum8}), 64'h046);
      end
      step();
      check("b2b second done", 64'(done8), 64'd1);
      check("b2b second result", 64'({co8, sum8}), 64'h111);
      step();

      // Random sets at both widths against integer addition.
      for (int i = 0; i < 1000; i++)
         run8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");

      run1(1'b1, 1'b1, 1'b1, "w1 111");
      run1(1'b1, 1'b0, 1'b0, "w1 100");
      for (int i = 0; i < 1000; i++)
         run1(1'($urandom), 1'($urandom), 1'($urandom), "rand1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
